hd44780_byte_sender: RTL and testbench
======================================

Name: hd44780_byte_sender

Overview:
- Downstream stage of the LCD controller path. Turns one command/data byte into two timed 4-bit HD44780 write cycles on lcd_rs/lcd_e/lcd_data.
- Also sends a single high nybble, which the 4-bit-mode init sequence needs.
- Handles only the short bus timing (tAS, PWEH, tcycE). Long post-command delays (53us, 4.1ms, ...) stay with the controller's state timer, which is started from end_strobe.

Parameters:
- TICKS_TAS, 3, clocks with RS/data stable and E low before E rises (H4NS_TICKS_TAS); must be >=1.
- TICKS_PWEH, 22, clocks E is held high (H4NS_TICKS_PWEH); must be >=1.
- TICKS_TCYCE, 48, total clocks per nybble cycle, from data presented to next data presented (H4NS_TICKS_TCYCE); must be >= TICKS_TAS+TICKS_PWEH+1.
- COUNT_BITS, 6, phase counter width (H4NS_COUNT_BITS); must hold TICKS_TCYCE-1.

Ports:
- CLK_I  in  1  system clock (48 MHz build).
- RST_I  in  1  reset, synchronous, active-low.
- DAT_I  in  8  byte to send; [7:4] goes first.
- rs_i  in  1  register select sampled with the byte (0=command, 1=data).
- nyb_only_i  in  1  1 = send only DAT_I[7:4] as a single nybble cycle.
- start_strobe  in  1  one-cycle request; sampled only when busy=0.
- busy  out  1  high while a transfer is in progress.
- end_strobe  out  1  one-cycle pulse when the transfer completes.
- lcd_rs  out  1  LCD RS pin.
- lcd_e  out  1  LCD E pin.
- lcd_data  out  4  LCD DB7..DB4.

Behaviour:
- Reset (RST_I=0 at a clock edge): state IDLE. lcd_e=0, lcd_rs=0, lcd_data=0, busy=0, end_strobe=0, counter=0.
- Reset mid-transfer aborts immediately. E drops low on that same edge.
- All outputs are registered. No combinational path from inputs to outputs.
- Accept:
  - In IDLE, start_strobe=1 at edge k latches DAT_I, rs_i and nyb_only_i.
  - From edge k+1: busy=1, lcd_rs=latched rs, lcd_data=DAT_I[7:4], lcd_e=0.
- States:
  - IDLE -> SETUP -> EHIGH -> HOLD -> (SETUP for the low nybble | DONE).
  - DONE lasts one cycle, then IDLE.
- Nybble cycle timing, relative to the first cycle t0 that the nybble is on lcd_data:
  - SETUP: cycles t0 .. t0+TAS-1, E=0.
  - EHIGH: cycles t0+TAS .. t0+TAS+PWEH-1, E=1.
  - HOLD: cycles t0+TAS+PWEH .. t0+TCYCE-1, E=0. RS/data unchanged.
- The low nybble (DAT_I[7:4] replaced by [3:0]) appears at t0+TCYCE. RS is unchanged.
- RS and data never change while E=1 or on the cycle E falls.
- Done:
  - end_strobe=1 for exactly one cycle, at k+1+TCYCE for a nybble-only transfer and k+1+2*TCYCE for a full byte.
  - busy is 0 in that same cycle.
- After completion lcd_rs/lcd_data hold their last values and lcd_e stays 0 until the next accept.
- start_strobe while busy=1 is ignored: no queueing, no effect on the transfer in progress.
- start_strobe in the end_strobe cycle is accepted, so back-to-back transfers are allowed. The next data appears on the following cycle.
- Counter resets to 0 at each phase change and never wraps within a phase. Phase-end compares are exact equality on COUNT_BITS-wide values.
- DAT_I/rs_i changes after accept have no effect on the transfer in progress.

Test Plan:
- Reset: hold RST_I=0 for 3 clocks with start_strobe=1 -> all outputs 0, no E pulse, busy stays 0.
- Data byte, defaults: DAT_I=0x41, rs_i=1, start at cycle 0. Required:
  - lcd_rs=1 from cycle 1.
  - lcd_data=4 in cycles 1-48, with E=1 in cycles 4-25.
  - lcd_data=1 from cycle 49, with E=1 in cycles 52-73.
  - end_strobe only at cycle 97; busy=1 in cycles 1-96.
- Nybble-only: DAT_I=0x30, rs_i=0, nyb_only_i=1. Required:
  - one E pulse (cycles 4-25) with lcd_data=3 and lcd_rs=0.
  - end_strobe at cycle 49; lcd_data stays 3 afterwards.
- Ignore while busy: start 0x28, then a second start with 0xFF at cycle 30 -> data sequence is exactly 2 then 8, end_strobe at 97 only.
- Back-to-back: a second start with 0x0C, rs=0, asserted in the end_strobe cycle 97 -> lcd_data=0 at cycle 98, E rises at 101, second end_strobe at 194.
- Reset mid-transfer: RST_I=0 at cycle 10 (E high) -> lcd_e=0 from cycle 11, no end_strobe. A new start after release runs the full correct timing.

Source files
------------

// File: rtl/hd44780_byte_sender.sv
// rtl/hd44780_byte_sender.sv - two timed 4-bit HD44780 write cycles per byte (or one for a lone nybble)
module hd44780_byte_sender #(
    parameter int TICKS_TAS   = 3,
    parameter int TICKS_PWEH  = 22,
    parameter int TICKS_TCYCE = 48,
    parameter int COUNT_BITS  = 6
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] DAT_I,
    input  logic       rs_i,
    input  logic       nyb_only_i,
    input  logic       start_strobe,
    output logic       busy,
    output logic       end_strobe,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_data
);

    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, DONE} state_t;

    localparam logic [COUNT_BITS-1:0] TAS_LAST  = COUNT_BITS'(TICKS_TAS - 1);
    localparam logic [COUNT_BITS-1:0] PWEH_LAST = COUNT_BITS'(TICKS_PWEH - 1);
    localparam logic [COUNT_BITS-1:0] HOLD_LAST = COUNT_BITS'(TICKS_TCYCE - TICKS_TAS - TICKS_PWEH - 1);

    state_t                state;
    logic [COUNT_BITS-1:0] cnt;
    logic [3:0]            low_nyb;
    logic                  second_pending;
    logic                  accept;

    // DONE accepts too, so a new transfer can follow end_strobe with no gap
    assign accept = start_strobe && ((state == IDLE) || (state == DONE));

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state          <= IDLE;
            cnt            <= '0;
            low_nyb        <= '0;
            second_pending <= 1'b0;
            busy           <= 1'b0;
            end_strobe     <= 1'b0;
            lcd_rs         <= 1'b0;
            lcd_e          <= 1'b0;
            lcd_data       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    end_strobe <= 1'b0;
                    if (accept) begin
                        state          <= SETUP;
                        busy           <= 1'b1;
                        lcd_rs         <= rs_i;
                        lcd_data       <= DAT_I[7:4];
                        low_nyb        <= DAT_I[3:0];
                        second_pending <= !nyb_only_i;
                        cnt            <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    if (cnt == TAS_LAST) begin
                        state <= EHIGH;
                        lcd_e <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + COUNT_BITS'(1);
                    end
                end
                EHIGH: begin
                    if (cnt == PWEH_LAST) begin
                        state <= HOLD;
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + COUNT_BITS'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (second_pending) begin
                            state          <= SETUP;
                            lcd_data       <= low_nyb;
                            second_pending <= 1'b0;
                        end else begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            end_strobe <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + COUNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_byte_sender.sv
// tb/tb_hd44780_byte_sender.sv - scoreboard bench for hd44780_byte_sender
module tb_hd44780_byte_sender;

    localparam int TAS   = 3;
    localparam int PWEH  = 22;
    localparam int TCYCE = 48;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic       rs_i = 1'b0;
    logic       nyb_only_i = 1'b0;
    logic       start_strobe = 1'b0;
    logic       busy, end_strobe, lcd_rs, lcd_e;
    logic [3:0] lcd_data;

    hd44780_byte_sender dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .rs_i(rs_i),
        .nyb_only_i(nyb_only_i), .start_strobe(start_strobe),
        .busy(busy), .end_strobe(end_strobe),
        .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 CLK_I = ~CLK_I;

    int cyc = 0;
    always @(posedge CLK_I) cyc <= cyc + 1;

    typedef struct {
        int         present;
        int         rise;
        int         fall;
        logic       rs;
        logic [3:0] d;
    } nyb_t;

    nyb_t nyb_q[$];
    int   end_q[$];
    nyb_t cur;
    bit   cur_valid = 0;
    int   m_t0 = 0;
    int   m_end = 0;
    bit   mon_en = 0;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    // Reference: a transfer accepted in cycle S presents each nybble for TCYCE
    // cycles starting S+1, with E high from TAS to TAS+PWEH into each one.
    task automatic attempt(input logic [7:0] b, input logic rs, input logic nyb);
        nyb_t n;
        DAT_I = b;
        rs_i = rs;
        nyb_only_i = nyb;
        start_strobe = 1'b1;
        if (RST_I && cyc >= m_end) begin
            m_t0 = cyc + 1;
            n.present = m_t0;
            n.rise = m_t0 + TAS;
            n.fall = m_t0 + TAS + PWEH;
            n.rs = rs;
            n.d = b[7:4];
            nyb_q.push_back(n);
            if (!nyb) begin
                n.present = m_t0 + TCYCE;
                n.rise = n.present + TAS;
                n.fall = n.present + TAS + PWEH;
                n.d = b[3:0];
                nyb_q.push_back(n);
            end
            m_end = m_t0 + (nyb ? TCYCE : 2 * TCYCE);
            end_q.push_back(m_end);
        end
        step(1);
        start_strobe = 1'b0;
        DAT_I = 8'($urandom);
        rs_i = 1'($urandom);
        nyb_only_i = 1'($urandom);
    endtask

    task automatic reset_pulse();
        RST_I = 1'b0;
        start_strobe = 1'($urandom);
        step(1);
        nyb_q.delete();
        end_q.delete();
        cur_valid = 0;
        m_t0 = 0;
        m_end = 0;
        RST_I = 1'b1;
        start_strobe = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= m_end + 1) step(1);
    endtask

    always @(negedge CLK_I) begin : monitor
        logic e_exp;
        logic busy_exp;
        if (mon_en) begin
            if (nyb_q.size() > 0 && nyb_q[0].present == cyc) begin
                cur = nyb_q.pop_front();
                cur_valid = 1;
            end
            e_exp = cur_valid && cyc >= cur.rise && cyc < cur.fall;
            chk("lcd_e", lcd_e, e_exp);
            if (cur_valid && cyc <= cur.fall) begin
                chk("lcd_data", lcd_data, cur.d);
                chk("lcd_rs", lcd_rs, cur.rs);
            end
            busy_exp = cyc >= m_t0 && cyc < m_end;
            chk("busy", busy, busy_exp);
            if (end_q.size() > 0 && end_q[0] == cyc) begin
                void'(end_q.pop_front());
                chk("end_strobe", end_strobe, 1'b1);
            end else begin
                chk("end_strobe", end_strobe, 1'b0);
            end
        end
    end

    initial begin
        RST_I = 1'b0;
        start_strobe = 1'b1;
        DAT_I = 8'h41;
        step(1);
        mon_en = 1;
        step(2);
        @(negedge CLK_I);
        chk("rst_lcd_e", lcd_e, 1'b0);
        chk("rst_lcd_rs", lcd_rs, 1'b0);
        chk("rst_lcd_data", lcd_data, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_end_strobe", end_strobe, 1'b0);
        step(1);
        RST_I = 1'b1;
        start_strobe = 1'b0;
        step(2);

        attempt(8'h41, 1'b1, 1'b0);
        wait_idle();

        attempt(8'h30, 1'b0, 1'b1);
        wait_idle();
        @(negedge CLK_I);
        chk("nyb_hold_data", lcd_data, 4'h3);
        chk("nyb_hold_e", lcd_e, 1'b0);
        step(1);

        attempt(8'h28, 1'b1, 1'b0);
        step(29);
        attempt(8'hFF, 1'b1, 1'b0);
        wait_idle();

        attempt(8'h41, 1'b1, 1'b0);
        while (cyc < m_end) step(1);
        attempt(8'h0C, 1'b0, 1'b0);
        wait_idle();

        attempt(8'h55, 1'b1, 1'b0);
        step(9);
        reset_pulse();
        @(negedge CLK_I);
        chk("abort_e", lcd_e, 1'b0);
        chk("abort_busy", busy, 1'b0);
        step(1);
        attempt(8'h41, 1'b1, 1'b0);
        wait_idle();

        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) reset_pulse();
            else if (r < 40) attempt(8'($urandom), 1'($urandom), 1'($urandom));
            else begin
                DAT_I = 8'($urandom);
                rs_i = 1'($urandom);
                nyb_only_i = 1'($urandom);
                step(1);
            end
        end
        wait_idle();
        step(2);
        chk("nyb_q_drained", nyb_q.size(), 0);
        chk("end_q_drained", end_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
